// File: rtl/lfsr_prng.sv
// Fibonacci LFSR pseudo-random generator with free-run, single-step, serial shift-in
// and hold modes, seed load, all-zero lockup recovery and period measurement.
module lfsr_prng #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned      DIV   = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       i_mode,
    input  logic             i_step,
    input  logic             i_serial,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_state,
    output logic             o_bit,
    output logic             o_valid,
    output logic             o_wrap,
    output logic [WIDTH-1:0] o_period,
    output logic             o_lockup
);

    localparam int unsigned      PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0]    ONE_P     = PW'(1'b1);
    localparam logic [PW-1:0]    ZERO_P    = {PW{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [1:0]       MODE_FREE = 2'b00;
    localparam logic [1:0]       MODE_STEP = 2'b01;
    localparam logic [1:0]       MODE_SER  = 2'b10;

    function automatic logic fb_parity(input logic [WIDTH-1:0] v);
        fb_parity = ^(v & TAPS);
    endfunction

    logic [WIDTH-1:0] state_r, ref_r, cnt_r, period_r;
    logic [PW-1:0]    presc_r;
    logic [1:0]       mode_r;
    logic             step_r, step_prev_r;
    logic             valid_r, wrap_r, lockup_r;

    logic             mode_chg_s, step_edge_s, adv_s, shift_in_s;
    logic [PW-1:0]    presc_eff_s, presc_nxt_s;
    logic [WIDTH-1:0] ref_base_s, cnt_base_s, cnt_inc_s, shifted_s, seed_v_s;
    logic [WIDTH-1:0] state_nxt_s, ref_nxt_s, cnt_nxt_s, period_nxt_s;
    logic             valid_nxt_s, wrap_nxt_s, lockup_nxt_s;

    // Advance enable: prescaler restarts whenever the mode changes.
    always_comb begin
        mode_chg_s  = (i_mode != mode_r);
        presc_eff_s = mode_chg_s ? ZERO_P : presc_r;
        step_edge_s = step_r & ~step_prev_r;
        adv_s       = 1'b0;
        presc_nxt_s = presc_eff_s;
        case (i_mode)
            MODE_FREE: begin
                adv_s       = (presc_eff_s == PRESC_MAX);
                presc_nxt_s = adv_s ? ZERO_P : presc_eff_s + ONE_P;
            end
            MODE_STEP: adv_s = step_edge_s;
            MODE_SER:  adv_s = 1'b1;
            default:   adv_s = 1'b0;
        endcase
    end

    // Next-state selection: load > lockup recovery > advance > hold.
    always_comb begin
        ref_base_s   = (mode_chg_s && (i_mode == MODE_SER)) ? state_r : ref_r;
        cnt_base_s   = (mode_chg_s && (i_mode == MODE_SER)) ? ZERO_W : cnt_r;
        cnt_inc_s    = cnt_base_s + ONE_W;
        shift_in_s   = (i_mode == MODE_SER) ? i_serial : fb_parity(state_r);
        shifted_s    = {state_r[WIDTH-2:0], shift_in_s};
        seed_v_s     = (i_seed == ZERO_W) ? SEED : i_seed;
        state_nxt_s  = state_r;
        ref_nxt_s    = ref_base_s;
        cnt_nxt_s    = cnt_base_s;
        period_nxt_s = period_r;
        valid_nxt_s  = 1'b0;
        wrap_nxt_s   = 1'b0;
        lockup_nxt_s = 1'b0;
        if (i_load) begin
            state_nxt_s = seed_v_s;
            ref_nxt_s   = seed_v_s;
            cnt_nxt_s   = ZERO_W;
        end else if (adv_s && (state_r == ZERO_W) && (i_mode != MODE_SER)) begin
            state_nxt_s  = SEED;
            ref_nxt_s    = SEED;
            cnt_nxt_s    = ZERO_W;
            lockup_nxt_s = 1'b1;
        end else if (adv_s) begin
            state_nxt_s = shifted_s;
            valid_nxt_s = 1'b1;
            if (shifted_s == ref_base_s) begin
                wrap_nxt_s   = 1'b1;
                period_nxt_s = cnt_inc_s;
                cnt_nxt_s    = ZERO_W;
            end else begin
                cnt_nxt_s = cnt_inc_s;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, reference, counters and output pulse registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= SEED;
            ref_r       <= SEED;
            cnt_r       <= ZERO_W;
            period_r    <= ZERO_W;
            presc_r     <= ZERO_P;
            mode_r      <= MODE_FREE;
            step_r      <= 1'b0;
            step_prev_r <= 1'b0;
            valid_r     <= 1'b0;
            wrap_r      <= 1'b0;
            lockup_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ref_r       <= ref_nxt_s;
            cnt_r       <= cnt_nxt_s;
            period_r    <= period_nxt_s;
            presc_r     <= presc_nxt_s;
            mode_r      <= i_mode;
            step_r      <= i_step;
            step_prev_r <= step_r;
            valid_r     <= valid_nxt_s;
            wrap_r      <= wrap_nxt_s;
            lockup_r    <= lockup_nxt_s;
        end
    end

    assign o_state  = state_r;
    assign o_bit    = state_r[WIDTH-1];
    assign o_valid  = valid_r;
    assign o_wrap   = wrap_r;
    assign o_period = period_r;
    assign o_lockup = lockup_r;

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: two 4-bit instances (DIV=1 and DIV=3) on shared stimulus,
// checked every cycle against a behavioural model plus hand-computed sequences.
module tb_lfsr_prng;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [1:0] i_mode;
    logic       i_step, i_serial, i_load;
    logic [3:0] i_seed;
    logic [3:0] a_state, a_period, b_state, b_period;
    logic       a_bit, a_valid, a_wrap, a_lockup;
    logic       b_bit, b_valid, b_wrap, b_lockup;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    lfsr_prng #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .DIV(1)) u_a (
        .CLK(CLK), .RST_N(RST_N), .i_mode(i_mode), .i_step(i_step), .i_serial(i_serial),
        .i_load(i_load), .i_seed(i_seed), .o_state(a_state), .o_bit(a_bit),
        .o_valid(a_valid), .o_wrap(a_wrap), .o_period(a_period), .o_lockup(a_lockup));

    lfsr_prng #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .DIV(3)) u_b (
        .CLK(CLK), .RST_N(RST_N), .i_mode(i_mode), .i_step(i_step), .i_serial(i_serial),
        .i_load(i_load), .i_seed(i_seed), .o_state(b_state), .o_bit(b_bit),
        .o_valid(b_valid), .o_wrap(b_wrap), .o_period(b_period), .o_lockup(b_lockup));

    typedef struct {
        logic [3:0] state, refv, cnt, period;
        int         presc;
        logic [1:0] pmode;
        logic       s1, s2, valid, wrap, lockup;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.state = 4'd1; m.refv = 4'd1; m.cnt = 4'd0; m.period = 4'd0; m.presc = 0;
        m.pmode = 2'd0; m.s1 = 1'b0; m.s2 = 1'b0;
        m.valid = 1'b0; m.wrap = 1'b0; m.lockup = 1'b0;
        return m;
    endfunction

    // Next LFSR value from the rules: shift left, feedback = parity of tapped bits.
    function automatic logic [3:0] lfsr_next(input logic [3:0] v);
        int nv;
        nv = (int'(v) * 2 + ($countones(v & 4'h9) % 2)) % 16;
        return 4'(nv);
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic [1:0] mode, input logic step,
                                   input logic ser, input logic load, input logic [3:0] seed,
                                   input int div);
        mdl_t       n;
        bit         changed, edge_seen, adv;
        int         pre;
        logic [3:0] rf, cn, nxt, v;
        n = m;
        n.valid = 1'b0; n.wrap = 1'b0; n.lockup = 1'b0;
        changed   = (mode != m.pmode);
        pre       = changed ? 0 : m.presc;
        edge_seen = m.s1 && !m.s2;
        adv       = 1'b0;
        n.presc   = pre;
        if (mode == 2'd0) begin
            adv     = (pre == div - 1);
            n.presc = adv ? 0 : pre + 1;
        end else if (mode == 2'd1) adv = edge_seen;
        else if (mode == 2'd2) adv = 1'b1;
        n.s2 = m.s1; n.s1 = step; n.pmode = mode;
        rf = m.refv; cn = m.cnt;
        if (changed && mode == 2'd2) begin rf = m.state; cn = 4'd0; end
        n.refv = rf; n.cnt = cn;
        if (load) begin
            v = (seed == 4'd0) ? 4'd1 : seed;
            n.state = v; n.refv = v; n.cnt = 4'd0;
        end else if (adv && m.state == 4'd0 && mode != 2'd2) begin
            n.state = 4'd1; n.refv = 4'd1; n.cnt = 4'd0; n.lockup = 1'b1;
        end else if (adv) begin
            nxt = (mode == 2'd2) ? 4'((int'(m.state) * 2 + int'(ser)) % 16) : lfsr_next(m.state);
            n.state = nxt; n.valid = 1'b1;
            if (nxt == rf) begin
                n.wrap = 1'b1; n.period = cn + 4'd1; n.cnt = 4'd0;
            end else n.cnt = cn + 4'd1;
        end
        return n;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, i_mode, i_step, i_serial, i_load, i_seed, 1);
            mb <= mstep(mb, i_mode, i_step, i_serial, i_load, i_seed, 3);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: wait for the falling edge, then compare both instances to the model.
    task automatic tick();
        @(negedge CLK);
        chk("a_state", 32'(a_state), 32'(ma.state));
        chk("a_bit", 32'(a_bit), 32'(ma.state[3]));
        chk("a_valid", 32'(a_valid), 32'(ma.valid));
        chk("a_wrap", 32'(a_wrap), 32'(ma.wrap));
        chk("a_period", 32'(a_period), 32'(ma.period));
        chk("a_lockup", 32'(a_lockup), 32'(ma.lockup));
        chk("b_state", 32'(b_state), 32'(mb.state));
        chk("b_bit", 32'(b_bit), 32'(mb.state[3]));
        chk("b_valid", 32'(b_valid), 32'(mb.valid));
        chk("b_wrap", 32'(b_wrap), 32'(mb.wrap));
        chk("b_period", 32'(b_period), 32'(mb.period));
        chk("b_lockup", 32'(b_lockup), 32'(mb.lockup));
    endtask

    int exp_seq[15] = '{3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8, 1};

    initial begin
        int         vb, cnt, first, found;
        logic [3:0] sa, sb;
        RST_N = 1'b0; i_mode = 2'd0; i_step = 1'b0; i_serial = 1'b0;
        i_load = 1'b0; i_seed = 4'd0;
        repeat (3) tick();
        chk("rst_state", 32'(a_state), 32'd1);
        chk("rst_period", 32'(a_period), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);

        // Free-run from reset: full 15-state sequence, DIV=3 instance advances every 3rd clock
        RST_N = 1'b1;
        vb = 0; first = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("fr_seq", 32'(a_state), 32'(exp_seq[i]));
            chk("fr_valid", 32'(a_valid), 32'd1);
            if (b_valid) begin
                vb++;
                if (first == 0) first = i + 1;
            end
        end
        chk("fr_wrap", 32'(a_wrap), 32'd1);
        chk("fr_period", 32'(a_period), 32'd15);
        chk("div3_valids", 32'(vb), 32'd5);
        chk("div3_first_adv", 32'(first), 32'd3);

        // Hold freezes both, resume continues without skip
        repeat (2) tick();
        sa = a_state; sb = b_state;
        i_mode = 2'd3;
        repeat (5) tick();
        chk("hold_a", 32'(a_state), 32'(sa));
        chk("hold_b", 32'(b_state), 32'(sb));
        i_mode = 2'd0;
        tick();
        chk("resume_a", 32'(a_state), 32'(lfsr_next(sa)));
        repeat (3) tick();
        chk("resume_b", 32'(b_state), 32'(lfsr_next(sb)));

        // Randomised mix of all modes, loads and serial data
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) i_mode = 2'($urandom_range(0, 3));
            i_step   = 1'($urandom);
            i_serial = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            i_load   = ($urandom_range(0, 19) == 0);
            i_seed   = 4'($urandom);
            tick();
        end
        i_load = 1'b0;

        // Single-step: held step gives exactly one advance
        i_mode = 2'd1; i_step = 1'b0; i_load = 1'b1; i_seed = 4'd1;
        tick();
        i_load = 1'b0;
        repeat (2) tick();
        i_step = 1'b1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_valid) cnt++;
        end
        chk("step_once", 32'(cnt), 32'd1);
        chk("step_state", 32'(a_state), 32'd3);
        i_step = 1'b0;
        repeat (2) tick();
        i_step = 1'b1;
        repeat (3) tick();
        chk("step_second", 32'(a_state), 32'd7);

        // Serial zeros reach the all-zero state, free-run then recovers
        i_mode = 2'd2; i_serial = 1'b0; cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_lockup) cnt++;
        end
        chk("ser_zero", 32'(a_state), 32'd0);
        chk("ser_no_lockup", 32'(cnt), 32'd0);
        i_mode = 2'd0;
        tick();
        chk("lock_state", 32'(a_state), 32'd1);
        chk("lock_pulse", 32'(a_lockup), 32'd1);
        chk("lock_valid", 32'(a_valid), 32'd0);

        // Loads: zero seed maps to SEED; load beats a pending step edge
        i_mode = 2'd1; i_step = 1'b0; i_load = 1'b1; i_seed = 4'd0;
        tick();
        chk("load_zero", 32'(a_state), 32'd1);
        i_load = 1'b0;
        repeat (2) tick();
        i_step = 1'b1;
        tick();
        i_load = 1'b1; i_seed = 4'hA;
        tick();
        chk("load_a", 32'(a_state), 32'd10);
        chk("load_novalid", 32'(a_valid), 32'd0);
        i_load = 1'b0; i_mode = 2'd0;
        repeat (15) tick();
        chk("reload_state", 32'(a_state), 32'd10);
        chk("reload_wrap", 32'(a_wrap), 32'd1);
        chk("reload_period", 32'(a_period), 32'd15);

        // Asynchronous reset in the middle of free-run at state D
        i_load = 1'b1; i_seed = 4'd1;
        tick();
        i_load = 1'b0; found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (a_state == 4'hD) found = 1;
        end
        chk("reach_d", 32'(found), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_state", 32'(a_state), 32'd1);
        chk("arst_b_state", 32'(b_state), 32'd1);
        chk("arst_valid", 32'(a_valid), 32'd0);
        chk("arst_wrap", 32'(a_wrap), 32'd0);
        chk("arst_lockup", 32'(a_lockup), 32'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
